// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-slice modulo-N counter: JK control codes and helpers.
package jk_counter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Force code that drives a slice to tgt_bit; hold when it is already there.
    function automatic logic [1:0] next_jk(input logic cur_bit, input logic tgt_bit);
        if (cur_bit == tgt_bit) return JK_HOLD;
        return tgt_bit ? JK_SET : JK_RST;
    endfunction

endpackage

// File: rtl/jk_slice.sv
// One falling-edge JK bit cell with synchronous active-low clear.
module jk_slice
    import jk_counter_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic [1:0] jk_i,
    output logic       q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (jk_i)
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(negedge clk_i) begin
        if (!clr_i) q_q <= 1'b0;
        else        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_counter_mod.sv
// Synchronous up/down modulo-N counter built from WIDTH JK slices on a common falling-edge clock.
module jk_counter_mod
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             pr_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             err_o
);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
        $error("jk_counter_mod: WIDTH or MODULUS out of range");
    end

    localparam int unsigned     MOD_U   = MODULUS;
    localparam int unsigned     MAX_U   = MODULUS - 1;
    localparam logic [WIDTH:0]  MOD_W   = MOD_U[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_Q  = MAX_U[WIDTH-1:0];
    localparam bit              POW2    = (MODULUS == (1 << WIDTH));

    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0][1:0] jk;
    logic [WIDTH-1:0]      tgt;
    logic [WIDTH-1:0]      tog;
    logic                  use_force;
    logic                  carry;
    logic                  in_range;
    logic                  err_q;
    logic                  err_d;

    assign in_range = POW2 || ({1'b0, q} < MOD_W);

    always_comb begin
        tgt       = q;
        tog       = '0;
        use_force = 1'b0;
        carry     = 1'b1;
        err_d     = err_q;
        jk        = '0;

        if (!pr_i) begin
            tgt       = MAX_Q;
            use_force = 1'b1;
        end else if (load_i) begin
            use_force = 1'b1;
            if ({1'b0, d_i} < MOD_W) begin
                tgt = d_i;
            end else begin
                tgt   = MAX_Q;
                err_d = 1'b1;
            end
        end else if (en_i) begin
            // Out-of-range states and non-power-of-two wraps jump straight to the target.
            if (!in_range) begin
                tgt       = up_i ? '0 : MAX_Q;
                use_force = 1'b1;
            end else if (!POW2 && up_i && (q == MAX_Q)) begin
                tgt       = '0;
                use_force = 1'b1;
            end else if (!POW2 && !up_i && (q == '0)) begin
                tgt       = MAX_Q;
                use_force = 1'b1;
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    tog[i] = carry;
                    carry  = carry & (up_i ? q[i] : ~q[i]);
                end
            end
        end

        for (int i = 0; i < WIDTH; i++) begin
            if (use_force) jk[i] = next_jk(q[i], tgt[i]);
            else           jk[i] = tog[i] ? JK_TOG : JK_HOLD;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_slice u_slice (
            .clk_i (clk_i),
            .clr_i (clr_i),
            .jk_i  (jk[i]),
            .q_o   (q[i])
        );
    end

    always_ff @(negedge clk_i) begin
        if (!clr_i) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign q_o   = q;
    assign err_o = err_q;
    assign tc_o  = en_i & in_range & (up_i ? (q == MAX_Q) : (q == '0));

endmodule

// File: tb/tb_jk_counter_mod.sv
// Bench for jk_counter_mod: vector table, corner sequences, cascade, and randomized model comparison.
module tb_jk_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: WIDTH=4, MODULUS=10
    logic       a_clr, a_pr, a_en, a_up, a_load;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_err;

    // Instance C: WIDTH=3, MODULUS=8
    logic       c_clr, c_pr, c_en, c_up, c_load;
    logic [2:0] c_d, c_q;
    logic       c_tc, c_err;

    // Cascade: units -> tens
    logic       k_clr;
    logic [3:0] u_q, t_q;
    logic       u_tc, t_tc, u_err, t_err;

    jk_counter_mod #(.WIDTH(4), .MODULUS(10)) u_a (
        .clk_i(clk), .clr_i(a_clr), .pr_i(a_pr), .en_i(a_en), .up_i(a_up),
        .load_i(a_load), .d_i(a_d), .q_o(a_q), .tc_o(a_tc), .err_o(a_err));

    jk_counter_mod #(.WIDTH(3), .MODULUS(8)) u_c (
        .clk_i(clk), .clr_i(c_clr), .pr_i(c_pr), .en_i(c_en), .up_i(c_up),
        .load_i(c_load), .d_i(c_d), .q_o(c_q), .tc_o(c_tc), .err_o(c_err));

    jk_counter_mod #(.WIDTH(4), .MODULUS(10)) u_units (
        .clk_i(clk), .clr_i(k_clr), .pr_i(1'b1), .en_i(1'b1), .up_i(1'b1),
        .load_i(1'b0), .d_i(4'd0), .q_o(u_q), .tc_o(u_tc), .err_o(u_err));

    jk_counter_mod #(.WIDTH(4), .MODULUS(10)) u_tens (
        .clk_i(clk), .clr_i(k_clr), .pr_i(1'b1), .en_i(u_tc), .up_i(1'b1),
        .load_i(1'b0), .d_i(4'd0), .q_o(t_q), .tc_o(t_tc), .err_o(t_err));

    typedef struct {
        logic clr, pr, load, en, up;
        logic [3:0] d;
        int   q;
        logic tc, err;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Advance past one active (falling) edge and settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_a(input logic clr, pr, load, en, up, input logic [3:0] d);
        a_clr = clr; a_pr = pr; a_load = load; a_en = en; a_up = up; a_d = d;
    endtask

    // Reference model from the behavioural rules.
    function automatic int mdl_q(int q, int m, logic clr, pr, load, en, up, int d);
        if (!clr) return 0;
        if (!pr) return m - 1;
        if (load) return (d < m) ? d : m - 1;
        if (en) begin
            if (q >= m) return up ? 0 : m - 1;
            return up ? (q + 1) % m : (q + m - 1) % m;
        end
        return q;
    endfunction

    function automatic int mdl_err(int e, int m, logic clr, pr, load, int d);
        if (!clr) return 0;
        if (!pr) return e;
        if (load && d >= m) return 1;
        return e;
    endfunction

    function automatic int mdl_tc(int q, int m, logic en, up);
        return (en && q < m && (up ? q == m - 1 : q == 0)) ? 1 : 0;
    endfunction

    initial begin
        int maq, mae, mcq, mce;
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        c_clr = 1'b0; c_pr = 1'b1; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_d = 3'd0;
        k_clr = 1'b0;

        //             clr   pr    load  en    up    d      q  tc    err
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  9, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  8, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  7, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  7, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  7, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6,  6, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd13, 9, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  9, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 9, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd14, 0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  9, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  8, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  9, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  0, 1'b0, 1'b0};

        step();
        step();
        foreach (tbl[i]) begin
            drive_a(tbl[i].clr, tbl[i].pr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].d);
            step();
            chk($sformatf("tbl%0d_q", i), int'(a_q), tbl[i].q);
            chk($sformatf("tbl%0d_tc", i), int'(a_tc), int'(tbl[i].tc));
            chk($sformatf("tbl%0d_err", i), int'(a_err), int'(tbl[i].err));
        end

        // Up count from reset across the wrap.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        step();
        a_clr = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("up%0d_q", k), int'(a_q), k % 10);
            chk($sformatf("up%0d_tc", k), int'(a_tc), (k % 10 == 9) ? 1 : 0);
        end

        // Reset while counting at 5 lands on the same edge.
        a_clr = 1'b0;
        step();
        a_clr = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("cnt_at5", int'(a_q), 5);
        a_clr = 1'b0;
        step();
        chk("clr_mid_count", int'(a_q), 0);
        a_clr = 1'b1;
        step();
        chk("after_clr_count", int'(a_q), 1);

        // Illegal state 12 recovers to 0 counting up and to 9 counting down.
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        step();
        a_clr = 1'b1;
        for (int dir = 1; dir >= 0; dir--) begin
            #2;
            force u_a.g_bit[3].u_slice.q_q = 1'b1;
            force u_a.g_bit[2].u_slice.q_q = 1'b1;
            #1;
            release u_a.g_bit[3].u_slice.q_q;
            release u_a.g_bit[2].u_slice.q_q;
            a_en = 1'b1;
            a_up = dir[0];
            #1;
            chk($sformatf("illegal_q_dir%0d", dir), int'(a_q), 12);
            chk($sformatf("illegal_tc_dir%0d", dir), int'(a_tc), 0);
            step();
            chk($sformatf("recover_dir%0d", dir), int'(a_q), dir ? 0 : 9);
            a_en = 1'b0;
            step();
        end

        // Power-of-two modulus wraps both ways.
        step();
        c_clr = 1'b1; c_en = 1'b1; c_up = 1'b1;
        for (int k = 0; k < 7; k++) step();
        chk("c_at7_q", int'(c_q), 7);
        chk("c_at7_tc", int'(c_tc), 1);
        step();
        chk("c_wrap_up", int'(c_q), 0);
        c_up = 1'b0;
        #1;
        chk("c_at0_down_tc", int'(c_tc), 1);
        step();
        chk("c_wrap_down", int'(c_q), 7);

        // Two-digit decimal cascade.
        step();
        k_clr = 1'b1;
        #1;
        chk("casc_start", int'(t_q) * 10 + int'(u_q), 0);
        for (int k = 1; k <= 100; k++) begin
            step();
            chk($sformatf("casc%0d_val", k), int'(t_q) * 10 + int'(u_q), k % 100);
            chk($sformatf("casc%0d_tc", k), int'(t_tc), (k % 100 == 99) ? 1 : 0);
        end
        chk("casc_err", int'(u_err | t_err), 0);

        // Randomized controls on both instances against the model.
        maq = 0; mae = 0; mcq = 0; mce = 0;
        for (int n = 0; n < 400; n++) begin
            logic clr, pr, load, en, up;
            logic [3:0] d;
            clr  = (n == 0) ? 1'b0 : ($urandom_range(31) != 0);
            pr   = ($urandom_range(15) != 0);
            load = ($urandom_range(7) == 0);
            en   = ($urandom_range(3) != 0);
            up   = $urandom_range(1) != 0;
            d    = 4'($urandom_range(15));
            drive_a(clr, pr, load, en, up, d);
            c_clr = clr; c_pr = pr; c_load = load; c_en = en; c_up = up; c_d = d[2:0];
            step();
            maq = mdl_q(maq, 10, clr, pr, load, en, up, int'(d));
            mae = mdl_err(mae, 10, clr, pr, load, int'(d));
            mcq = mdl_q(mcq, 8, clr, pr, load, en, up, int'(d[2:0]));
            mce = mdl_err(mce, 8, clr, pr, load, int'(d[2:0]));
            chk($sformatf("rnd%0d_a_q", n), int'(a_q), maq);
            chk($sformatf("rnd%0d_a_tc", n), int'(a_tc), mdl_tc(maq, 10, en, up));
            chk($sformatf("rnd%0d_a_err", n), int'(a_err), mae);
            chk($sformatf("rnd%0d_c_q", n), int'(c_q), mcq);
            chk($sformatf("rnd%0d_c_tc", n), int'(c_tc), mdl_tc(mcq, 8, en, up));
            chk($sformatf("rnd%0d_c_err", n), int'(c_err), mce);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
